// File: rtl/fifo.sv
// Single-clock synchronous FIFO with wrap-bit pointers and a registered read port.
// Optional sticky overflow/underflow flags are built when FIFO_STICKY_ERR_EN is defined.
module fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_SIZE   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
`ifdef FIFO_STICKY_ERR_EN
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  empty
`endif
);

    localparam int ADDR_W = PTR_SIZE - 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_SIZE-1:0]   wr_ptr_r;
    logic [PTR_SIZE-1:0]   rd_ptr_r;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic [ADDR_W-1:0]     wr_addr_s;
    logic [ADDR_W-1:0]     rd_addr_s;

    assign wr_addr_s = wr_ptr_r[ADDR_W-1:0];
    assign rd_addr_s = rd_ptr_r[ADDR_W-1:0];

    // Flags decode straight from the registered pointers; the wrap bit separates full from empty.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PTR_SIZE-1] != rd_ptr_r[PTR_SIZE-1]) &&
                  (wr_addr_s == rd_addr_s);
        wr_ok_s = wr_en && !full_s;
        rd_ok_s = rd_en && !empty_s;
    end

    // Storage array: no reset, written only on accepted writes outside reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !rst_n) begin
            mem_r[wr_addr_s] <= din;
        end
    end

    // Pointers and registered read data; reset (logic 1 on rst_n) wins over any request.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_r <= {PTR_SIZE{1'b0}};
            rd_ptr_r <= {PTR_SIZE{1'b0}};
            dout_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_SIZE'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_SIZE'(1);
                dout_r   <= mem_r[rd_addr_s];
            end
        end
    end

    assign dout  = dout_r;
    assign full  = full_s;
    assign empty = empty_s;

`ifdef FIFO_STICKY_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error capture; observes rejected requests only and never touches the datapath.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end
            if (rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: directed phases plus random traffic against a queue-based reference.
module tb_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = 8'h00;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
`ifdef FIFO_STICKY_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    typedef struct {
        logic [DW-1:0] dout;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          udf;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout = 8'h00;
    logic          model_ovf  = 1'b0;
    logic          model_udf  = 1'b0;
    int            tests      = 0;
    int            fails      = 0;

    fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_SIZE(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .din      (din),
        .dout     (dout),
        .full     (full),
`ifdef FIFO_STICKY_ERR_EN
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
`else
        .empty    (empty)
`endif
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: drive inputs, advance the reference, queue what the edge should produce.
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        exp_t e;
        bit   was_empty;
        bit   was_full;
        @(negedge clk);
        rst_n = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        if (r) begin
            model_q.delete();
            model_dout = 8'h00;
            model_ovf  = 1'b0;
            model_udf  = 1'b0;
        end else begin
            was_empty = (model_q.size() == 0);
            was_full  = (model_q.size() == DEPTH);
            if (w && was_full) model_ovf = 1'b1;
            if (rd && was_empty) model_udf = 1'b1;
            if (rd && !was_empty) model_dout = model_q.pop_front();
            if (w && !was_full) model_q.push_back(d);
        end
        e.dout  = model_dout;
        e.empty = (model_q.size() == 0);
        e.full  = (model_q.size() == DEPTH);
        e.ovf   = model_ovf;
        e.udf   = model_udf;
        exp_q.push_back(e);
    endtask

    // Monitor: after every edge, retire the oldest expectation and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (dout !== e.dout) begin
                fails++;
                $display("FAIL dout: got %h expected %h at %0t", dout, e.dout, $time);
            end
            tests++;
            if (empty !== e.empty) begin
                fails++;
                $display("FAIL empty: got %b expected %b at %0t", empty, e.empty, $time);
            end
            tests++;
            if (full !== e.full) begin
                fails++;
                $display("FAIL full: got %b expected %b at %0t", full, e.full, $time);
            end
`ifdef FIFO_STICKY_ERR_EN
            tests++;
            if (overflow !== e.ovf) begin
                fails++;
                $display("FAIL overflow: got %b expected %b at %0t", overflow, e.ovf, $time);
            end
            tests++;
            if (underflow !== e.udf) begin
                fails++;
                $display("FAIL underflow: got %b expected %b at %0t", underflow, e.udf, $time);
            end
`endif
        end
    end

    initial begin
        // Reset
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        // Fill and overflow attempt
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        // Idle, drain, underflow attempt
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        // Preload then simultaneous read/write across the pointer wrap
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, DW'(i + 4));
        // Reset mid-operation
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'(8'h50 + i));
        step(1'b1, 1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2))),
                 ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2))),
                 DW'($urandom()));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo.md
# fifo

Single-clock synchronous FIFO that buffers `DATA_WIDTH`-bit words between a producer and a consumer in the same clock domain. Storage is a `DEPTH`-entry register array addressed by read and write pointers that carry an extra wrap bit. `full` and `empty` flags are exported for flow control, and read data is presented on a registered output. This is the generic buffering primitive for datapath blocks that need rate decoupling without clock crossing.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `DATA_WIDTH`, 8: word width in bits.
- `PTR_SIZE`, 5: pointer width, equal to log2(`DEPTH`)+1. The MSB is the wrap bit.

- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: synchronous reset, active-high. The port name is kept for codebase compatibility; a logic 1 on `rst_n` resets the block.
- `wr_en`  in  1: write request.
- `rd_en`  in  1: read request.
- `din`  in  `DATA_WIDTH`: write data.
- `dout`  out  `DATA_WIDTH`: registered read data.
- `full`  out  1: all `DEPTH` entries are occupied.
- `empty`  out  1: no entries are occupied.
- `overflow`  out  1: sticky error flag. Present only with `FIFO_STICKY_ERR_EN`.
- `underflow`  out  1: sticky error flag. Present only with `FIFO_STICKY_ERR_EN`.

## Operation
- **Write accept:** a write is accepted when `wr_en && !full`. `mem[wr_ptr[PTR_SIZE-2:0]] <= din` and `wr_ptr` increments by 1.
- **Read accept:** a read is accepted when `rd_en && !empty`. `dout <= mem[rd_ptr[PTR_SIZE-2:0]]` and `rd_ptr` increments by 1.
- **Rejected requests:** a write while full or a read while empty is ignored. Pointers, memory and `dout` are unchanged.
- **Pointer wrap:** pointers are `PTR_SIZE` bits and increment modulo 2^`PTR_SIZE`. The address is the low log2(`DEPTH`) bits, so it wraps from `DEPTH`-1 to 0 naturally.
- **Flags:** both are combinational from the registered pointers.
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = (MSBs differ) && (low bits equal).
- **Simultaneous read and write:**
  - Each side is evaluated against the flags at the start of the cycle.
  - When neither full nor empty, both operations occur and occupancy is unchanged.
  - When empty, only the write occurs.
  - When full, only the read occurs.
- **`dout` hold:** `dout` keeps its last value when no read is accepted.
- **Storage contents:** memory is not reset. Contents are don't-care until written.

## Timing
- **Reset:** while `rst_n`=1 at a rising edge, the following are set:
  - `wr_ptr`=0, `rd_ptr`=0, `dout`=0.
  - `empty`=1, `full`=0.
  - `overflow`/`underflow`=0, when present.
- **Reset priority:** reset has priority over any simultaneous write or read.
- **Reset mid-operation:** all stored data is discarded, and `empty` reads 1 in the cycle after the reset edge.
- **Write to flag latency:** 1 cycle. `empty` deasserts after the edge that accepts the first write. `full` asserts after the edge that accepts the `DEPTH`-th write.
- **Read latency:** 1 cycle. `dout` shows the word after the edge that accepts the read. `empty` asserts after the edge that accepts the last read.
- **Throughput:** one write and one read per cycle are sustainable.
- **Write-to-read visibility:** a word written at edge N can be read at edge N+1 at the earliest, so it appears on `dout` after N+1.

## Configuration
- **`FIFO_STICKY_ERR_EN` defined:**
  - The `overflow` and `underflow` ports are present.
  - `overflow` sets on any edge where `wr_en && full`.
  - `underflow` sets on any edge where `rd_en && empty`.
  - Both are registered, sticky, and cleared only by reset.
  - They have no effect on data or pointers.
- **`FIFO_STICKY_ERR_EN` undefined:** the ports and their logic are absent, and rejected requests are silently dropped.

## Test plan
- **Reset:** hold `rst_n`=1 for 2 cycles, then release → `empty`=1, `full`=0, `dout`=0.
- **Fill:** with `wr_en`=1 for 16 cycles and `din`=0..15 → `empty`=0 after the first edge. `full`=1 after the 16th edge.
- **Overflow attempt:** write 0xAA on a 17th cycle with `wr_en`=1 → the write is ignored and `full` stays 1. `overflow`=1 if enabled.
- **Drain:**
  - Wait 3 idle cycles, then hold `rd_en`=1 for 16 cycles → `dout` shows 0,1,…,15 on successive cycles.
  - `full` drops after the first read. `empty`=1 after the 16th read.
  - A 17th read leaves `dout`=15. `underflow`=1 if enabled.
- **Simultaneous and wrap:**
  - Preload 4 words, then hold `wr_en`=`rd_en`=1 for 20 cycles with `din` incrementing from 4.
  - Occupancy stays 4 and `dout` runs 0..19 in order across the pointer wrap.
  - Neither flag toggles.
- **Reset mid-operation:** write 5 words, assert `rst_n`=1 for one edge → `empty`=1. A subsequent write of 0x3C and read returns `dout`=0x3C.
